apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Round-robin scheduler that shares the single APB master between four transfer requesters (ALU result sources, config writers).
- Latches one request at a time and presents it on the master's data/select inputs.
- Waits for the master to accept and complete the transfer, then acks or errors the owning requester.
- Includes a completion timeout so a stalled slave cannot lock the bus.

Parameters:
- m, 8, data width (matches APB master data width)
- TIMEOUT, 16, max cycles from accept to completion; 0 disables timeout
- TW, 5, timeout counter width; must satisfy 2^TW > TIMEOUT

Ports:
- PCLK  input  1  clock, all logic on rising edge
- PRESET  input  1  synchronous active-low reset
- req_valid  input  4  per-requester request; held until req_ack or req_err
- req_data  input  4*m  requester k data at bits [k*m +: m]
- req_sel  input  8  requester k slave select at bits [2k +: 2]
- req_ack  output  4  one-cycle pulse, transfer of requester k completed
- req_err  output  4  one-cycle pulse, transfer of requester k timed out
- o_data  output  m  data to master
- o_data_ready  output  1  request valid to master
- o_protocol_sel  output  2  slave select to master (0..3 → PSEL0..PSEL3)
- i_waiting  input  1  master idle and accepting
- i_pready  input  1  bus PREADY
- i_xfer_ack  input  1  one-cycle pulse from master on completed access phase
- o_busy  output  1  arbiter not in IDLE
- o_grant_id  output  2  index of current/last granted requester

Behaviour:
- All outputs are registered.
- Reset, when PRESET=0 at a PCLK edge:
  - state=IDLE; o_data=0, o_data_ready=0, o_protocol_sel=0.
  - req_ack=0, req_err=0, o_busy=0, o_grant_id=0.
  - Round-robin pointer last=3, so requester 0 has top priority after reset.
  - Timeout counter=0.
  - Reset mid-operation abandons the transfer with no ack/err.
- States are IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid bit is set, grant the first set bit searching from (last+1) mod 4 upward with wrap.
  - Latch req_data/req_sel of the winner into o_data/o_protocol_sel; o_grant_id=winner; last=winner.
  - Go to ISSUE; o_data_ready=1 and o_busy=1 from the next cycle.
  - With no request, stay in IDLE with all outputs at reset values, except o_grant_id, which holds.
- ISSUE:
  - o_data_ready=1; o_data/o_protocol_sel stay stable.
  - Accept occurs at an edge where i_waiting=1 and i_pready=1: go to WAIT, o_data_ready=0, counter=0.
  - If req_valid[grant] drops before accept: abort to IDLE, no ack/err.
  - No timeout applies in ISSUE.
- WAIT:
  - Counter increments each cycle.
  - i_xfer_ack=1: req_ack[grant]=1 for one cycle, go to IDLE.
  - Else if TIMEOUT≠0 and counter==TIMEOUT-1: req_err[grant]=1 for one cycle, go to IDLE.
  - If i_xfer_ack and timeout occur in the same cycle, ack wins.
  - Changes on req_valid/req_data are ignored.
- Back-to-back: IDLE is always visited for one cycle between grants, so minimum request-to-request spacing is 3 cycles plus master latency.
- The arbiter never asserts ack and err together, and never pulses them for a non-granted index.
- Fairness: a continuously requesting source waits at most 3 other grants.

Test Plan:
- Reset then req_valid=4'b0001, req_data[7:0]=8'hA5, req_sel[1:0]=2 → next cycle o_data_ready=1, o_data=A5, o_protocol_sel=2, o_grant_id=0; i_waiting=i_pready=1 → o_data_ready=0; i_xfer_ack pulse → req_ack=4'b0001 for exactly one cycle, o_busy=0 next.
- req_valid=4'b1111 held, master always acks 2 cycles after accept → grant order 0,1,2,3,0, each with its own data/select.
- After a grant of 1, req_valid=4'b0011 → grant goes to 0 (wrap), not 1.
- TIMEOUT=16, accept, then no i_xfer_ack → req_err[grant] pulses on cycle 16 after accept, state IDLE, no req_ack.
- i_xfer_ack on the same cycle as timeout expiry → req_ack only. Separately, req_valid dropped during ISSUE with i_waiting=0 → return to IDLE, no pulses.
- PRESET=0 while in WAIT → next cycle all outputs 0, later i_xfer_ack ignored; first post-reset grant with req_valid=4'b1100 goes to 2.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin arbiter sharing one APB master between four requesters
// Latches one request, hands it to the master, then acks or times out the owner.
module apb_req_arbiter #(
    parameter int m       = 8,
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic           PCLK,
    input  logic           PRESET,
    input  logic [3:0]     req_valid,
    input  logic [4*m-1:0] req_data,
    input  logic [7:0]     req_sel,
    output logic [3:0]     req_ack,
    output logic [3:0]     req_err,
    output logic [m-1:0]   o_data,
    output logic           o_data_ready,
    output logic [1:0]     o_protocol_sel,
    input  logic           i_waiting,
    input  logic           i_pready,
    input  logic           i_xfer_ack,
    output logic           o_busy,
    output logic [1:0]     o_grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam bit            LP_TO_EN   = (TIMEOUT != 0);
    localparam logic [TW-1:0] LP_TO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    state_t        r_state, w_state_next;
    logic [1:0]    r_last, w_last;
    logic [1:0]    r_grant, w_grant;
    logic [m-1:0]  r_data, w_data;
    logic [1:0]    r_sel, w_sel;
    logic          r_ready, w_ready;
    logic          r_busy, w_busy;
    logic [3:0]    r_ack, w_ack;
    logic [3:0]    r_err, w_err;
    logic [TW-1:0] r_cnt, w_cnt;
    logic          w_found;
    logic [1:0]    w_win;

    // Search starts just after the last winner so every source gets a turn.
    always_comb begin
        logic [1:0] v_idx;
        v_idx   = '0;
        w_found = 1'b0;
        w_win   = r_last;
        for (int i = 1; i <= 4; i++) begin
            v_idx = r_last + 2'(i);
            if (!w_found && req_valid[v_idx]) begin
                w_found = 1'b1;
                w_win   = v_idx;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_last       = r_last;
        w_grant      = r_grant;
        w_data       = r_data;
        w_sel        = r_sel;
        w_ready      = r_ready;
        w_busy       = r_busy;
        w_ack        = '0;
        w_err        = '0;
        w_cnt        = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_data  = '0;
                w_sel   = '0;
                w_ready = 1'b0;
                w_busy  = 1'b0;
                if (w_found) begin
                    w_state_next = ST_ISSUE;
                    w_last       = w_win;
                    w_grant      = w_win;
                    w_data       = req_data[w_win*m +: m];
                    w_sel        = req_sel[w_win*2 +: 2];
                    w_ready      = 1'b1;
                    w_busy       = 1'b1;
                end
            end
            ST_ISSUE: begin
                // A withdrawn request is abandoned silently, before any bus activity.
                if (!req_valid[r_grant]) begin
                    w_state_next = ST_IDLE;
                    w_ready      = 1'b0;
                    w_busy       = 1'b0;
                    w_data       = '0;
                    w_sel        = '0;
                end else if (i_waiting && i_pready) begin
                    w_state_next = ST_WAIT;
                    w_ready      = 1'b0;
                    w_cnt        = '0;
                end
            end
            ST_WAIT: begin
                w_cnt = r_cnt + 1'b1;
                if (i_xfer_ack) begin
                    w_ack        = 4'(1) << r_grant;
                    w_state_next = ST_IDLE;
                    w_busy       = 1'b0;
                    w_data       = '0;
                    w_sel        = '0;
                end else if (LP_TO_EN && (r_cnt == LP_TO_LAST)) begin
                    w_err        = 4'(1) << r_grant;
                    w_state_next = ST_IDLE;
                    w_busy       = 1'b0;
                    w_data       = '0;
                    w_sel        = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_ready      = 1'b0;
                w_busy       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            r_state <= ST_IDLE;
            r_last  <= 2'd3;
            r_grant <= '0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_ack   <= '0;
            r_err   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_last  <= w_last;
            r_grant <= w_grant;
            r_data  <= w_data;
            r_sel   <= w_sel;
            r_ready <= w_ready;
            r_busy  <= w_busy;
            r_ack   <= w_ack;
            r_err   <= w_err;
            r_cnt   <= w_cnt;
        end
    end

    assign req_ack        = r_ack;
    assign req_err        = r_err;
    assign o_data         = r_data;
    assign o_data_ready   = r_ready;
    assign o_protocol_sel = r_sel;
    assign o_busy         = r_busy;
    assign o_grant_id     = r_grant;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - scoreboard bench for apb_req_arbiter
module tb_apb_req_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [7:0]  req_sel;
    logic [3:0]  req_ack;
    logic [3:0]  req_err;
    logic [7:0]  o_data;
    logic        o_data_ready;
    logic [1:0]  o_protocol_sel;
    logic        i_waiting;
    logic        i_pready;
    logic        i_xfer_ack;
    logic        o_busy;
    logic [1:0]  o_grant_id;

    always #5 PCLK = ~PCLK;

    apb_req_arbiter #(.m(8), .TIMEOUT(16), .TW(5)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_data(req_data), .req_sel(req_sel),
        .req_ack(req_ack), .req_err(req_err),
        .o_data(o_data), .o_data_ready(o_data_ready), .o_protocol_sel(o_protocol_sel),
        .i_waiting(i_waiting), .i_pready(i_pready), .i_xfer_ack(i_xfer_ack),
        .o_busy(o_busy), .o_grant_id(o_grant_id)
    );

    typedef struct {
        bit         kind;
        logic [1:0] id;
        logic [7:0] data;
        logic [1:0] sel;
        logic [3:0] ack;
        logic [3:0] err;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    logic prev_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per grant presentation or completion pulse.
    always @(negedge PCLK) begin
        ev_t e;
        if (o_data_ready && !prev_ready) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_grant actual=%0d required=none", o_grant_id);
            end else begin
                e = exp_q.pop_front();
                chk("grant_event_kind", 32'(0), 32'(e.kind));
                chk("grant_id", o_grant_id, e.id);
                chk("grant_data", o_data, e.data);
                chk("grant_sel", o_protocol_sel, e.sel);
            end
        end
        if ((req_ack | req_err) != 4'b0) begin
            chk("ack_err_exclusive", req_ack & req_err, 0);
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_pulse actual=ack%0h/err%0h required=none", req_ack, req_err);
            end else begin
                e = exp_q.pop_front();
                chk("done_event_kind", 32'(1), 32'(e.kind));
                chk("done_ack", req_ack, e.ack);
                chk("done_err", req_err, e.err);
            end
        end
        prev_ready = o_data_ready;
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset();
        PRESET = 1'b0; req_valid = '0; i_waiting = 1'b0; i_pready = 1'b0; i_xfer_ack = 1'b0;
        tick(); tick();
        PRESET = 1'b1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_data_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ready_seen", o_data_ready, 1);
    endtask

    task automatic push_grant(input logic [1:0] id, input logic [7:0] d, input logic [1:0] s);
        ev_t e;
        e.kind = 1'b0; e.id = id; e.data = d; e.sel = s; e.ack = '0; e.err = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input logic [3:0] a, input logic [3:0] r);
        ev_t e;
        e.kind = 1'b1; e.id = '0; e.data = '0; e.sel = '0; e.ack = a; e.err = r;
        exp_q.push_back(e);
    endtask

    task automatic accept();
        i_waiting = 1'b1; i_pready = 1'b1;
        tick();
        i_waiting = 1'b0; i_pready = 1'b0;
        chk("accept_ready_low", o_data_ready, 0);
        chk("accept_busy_high", o_busy, 1);
    endtask

    task automatic run_grant(input logic [1:0] id, input logic [7:0] d, input logic [1:0] s,
                             input int ack_after);
        push_grant(id, d, s);
        wait_ready();
        accept();
        repeat (ack_after - 1) tick();
        push_done(4'(1) << id, 4'b0);
        i_xfer_ack = 1'b1;
        tick();
        i_xfer_ack = 1'b0;
        chk("done_busy_low", o_busy, 0);
    endtask

    logic [1:0] rr_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] rr_d  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    logic [1:0] rr_s  [5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};

    initial begin
        req_data = '0; req_sel = '0;
        do_reset();
        chk("rst_ready", o_data_ready, 0);
        chk("rst_data", o_data, 0);
        chk("rst_sel", o_protocol_sel, 0);
        chk("rst_ack", req_ack, 0);
        chk("rst_err", req_err, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_gid", o_grant_id, 0);

        // single transfer from requester 0
        req_data = 32'h000000A5; req_sel = 8'h02; req_valid = 4'b0001;
        run_grant(2'd0, 8'hA5, 2'd2, 1);
        chk("single_ack", req_ack, 4'b0001);
        req_valid = 4'b0;
        tick();
        chk("ack_one_cycle", req_ack, 0);

        // round robin with all four requesting
        do_reset();
        req_data = 32'h44332211; req_sel = 8'b00_01_10_11; req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) run_grant(rr_id[k], rr_d[k], rr_s[k], 2);
        req_valid = 4'b0;
        tick();

        // wrap: after grant 1, {1,0} requesting -> 0
        req_valid = 4'b0010;
        run_grant(2'd1, 8'h22, 2'd2, 1);
        req_valid = 4'b0011;
        run_grant(2'd0, 8'h11, 2'd3, 1);
        req_valid = 4'b0;
        tick();

        // timeout on requester 2
        req_valid = 4'b0100;
        push_grant(2'd2, 8'h33, 2'd1);
        wait_ready();
        accept();
        push_done(4'b0, 4'b0100);
        repeat (15) tick();
        chk("no_err_early", req_err, 0);
        tick();
        chk("timeout_err", req_err, 4'b0100);
        chk("timeout_no_ack", req_ack, 0);
        chk("timeout_idle", o_busy, 0);
        req_valid = 4'b0;
        tick();

        // ack coincident with expiry wins
        req_valid = 4'b1000;
        push_grant(2'd3, 8'h44, 2'd0);
        wait_ready();
        accept();
        repeat (15) tick();
        push_done(4'b1000, 4'b0);
        i_xfer_ack = 1'b1;
        tick();
        i_xfer_ack = 1'b0;
        chk("race_ack", req_ack, 4'b1000);
        chk("race_no_err", req_err, 0);
        req_valid = 4'b0;
        tick();

        // withdraw during ISSUE
        req_valid = 4'b0001;
        push_grant(2'd0, 8'h11, 2'd3);
        wait_ready();
        req_valid = 4'b0;
        tick();
        chk("abort_busy", o_busy, 0);
        chk("abort_ready", o_data_ready, 0);
        repeat (3) tick();
        chk("abort_no_pulse", req_ack | req_err, 0);

        // reset while in WAIT
        req_valid = 4'b0010;
        push_grant(2'd1, 8'h22, 2'd2);
        wait_ready();
        accept();
        PRESET = 1'b0; req_valid = 4'b0;
        tick();
        PRESET = 1'b1;
        chk("mid_rst_ready", o_data_ready, 0);
        chk("mid_rst_data", o_data, 0);
        chk("mid_rst_sel", o_protocol_sel, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_gid", o_grant_id, 0);
        chk("mid_rst_pulse", req_ack | req_err, 0);
        i_xfer_ack = 1'b1;
        tick();
        i_xfer_ack = 1'b0;
        chk("stale_xfer_ignored", req_ack, 0);
        req_valid = 4'b1100;
        run_grant(2'd2, 8'h33, 2'd1, 3);
        req_valid = 4'b0;
        repeat (2) tick();

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
